// File: rtl/vector_pkg.sv
// Shared point-word layout and read-side state encoding for the vector display path.
// Point word: [11:0] y, [23:12] x, [24] beam on, [31:25] reserved.
package vector_pkg;

    localparam int unsigned POINT_W     = 32;
    localparam int unsigned COORD_W     = 12;
    localparam int unsigned PT_Y_LSB    = 0;
    localparam int unsigned PT_Y_MSB    = 11;
    localparam int unsigned PT_X_LSB    = 12;
    localparam int unsigned PT_X_MSB    = 23;
    localparam int unsigned PT_BEAM_BIT = 24;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWaitRdy,
        StIssue,
        StGap
    } rd_state_e;

    function automatic logic [COORD_W-1:0] pt_x(input logic [POINT_W-1:0] pt);
        return pt[PT_X_MSB:PT_X_LSB];
    endfunction

    function automatic logic [COORD_W-1:0] pt_y(input logic [POINT_W-1:0] pt);
        return pt[PT_Y_MSB:PT_Y_LSB];
    endfunction

    function automatic logic pt_beam(input logic [POINT_W-1:0] pt);
        return pt[PT_BEAM_BIT];
    endfunction

endpackage

// File: rtl/point_ram.sv
// Two-bank point store: one write port, one registered read port (1-cycle latency).
// Address is {bank, ptr}; contents are not reset.
module point_ram #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W:0]   wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned WORDS = 2 ** (ADDR_W + 1);

    logic [DATA_W-1:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read data holds between reads, so it doubles as the latched command word.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_q[rd_addr];
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// Double-buffered display-list scheduler: fills the back bank from the point decoder while the
// front bank is replayed as draw/jump commands; banks swap only at a frame boundary.
module frame_scheduler
    import vector_pkg::*;
#(
    parameter int unsigned ADDR_W = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_valid,
    input  logic [POINT_W-1:0] wr_point,
    input  logic               wr_last,
    output logic               wr_ready,
    input  logic               ready,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               draw,
    output logic               jump,
    output logic               frame_active,
    output logic               overflow
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    logic [ADDR_W-1:0]  wptr_q, wptr_d;
    logic [LEN_W-1:0]   back_len_q, back_len_d;
    logic               swap_pending_q, swap_pending_d;
    logic               overflow_q, overflow_d;
    logic               wr_accept;
    logic               wr_frame_end;

    rd_state_e          state_q, state_d;
    logic               front_bank_q, front_bank_d;
    logic [LEN_W-1:0]   front_len_q, front_len_d;
    logic [ADDR_W-1:0]  rptr_q, rptr_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               frame_active_q, frame_active_d;
    logic               do_swap;
    logic               rd_last_point;
    logic               rd_en;
    logic [POINT_W-1:0] rd_word;

    // ---------------------------------------------------------------- write side

    assign wr_ready     = ~swap_pending_q;
    assign wr_accept    = wr_valid & wr_ready;
    // A full bank closes the frame as if wr_last had been seen.
    assign wr_frame_end = wr_accept & (wr_last | (&wptr_q));

    always_comb begin
        wptr_d         = wptr_q;
        back_len_d     = back_len_q;
        swap_pending_d = swap_pending_q;
        overflow_d     = overflow_q;
        if (wr_accept) begin
            wptr_d = wptr_q + ADDR_W'(1);
        end
        if (wr_frame_end) begin
            wptr_d         = '0;
            back_len_d     = {1'b0, wptr_q} + LEN_W'(1);
            swap_pending_d = 1'b1;
            if (!wr_last) begin
                overflow_d = 1'b1;
            end
        end
        // Never coincides with wr_frame_end: writes are blocked while a swap is pending.
        if (do_swap) begin
            swap_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q         <= '0;
            back_len_q     <= '0;
            swap_pending_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            wptr_q         <= wptr_d;
            back_len_q     <= back_len_d;
            swap_pending_q <= swap_pending_d;
            overflow_q     <= overflow_d;
        end
    end

    point_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (POINT_W)
    ) u_point_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr ({~front_bank_q, wptr_q}),
        .wr_data (wr_point),
        .rd_en   (rd_en),
        .rd_addr ({front_bank_q, rptr_q}),
        .rd_data (rd_word)
    );

    // ---------------------------------------------------------------- read side

    assign rd_last_point = ({1'b0, rptr_q} + LEN_W'(1)) >= front_len_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        front_bank_d   = front_bank_q;
        front_len_d    = front_len_q;
        rptr_d         = rptr_q;
        x_d            = x_q;
        y_d            = y_q;
        frame_active_d = frame_active_q;
        do_swap        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (swap_pending_q) begin
                    do_swap = 1'b1;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                state_d = StWaitRdy;
            end
            StWaitRdy: begin
                if (ready) begin
                    x_d     = pt_x(rd_word);
                    y_d     = pt_y(rd_word);
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StGap;
            end
            StGap: begin
                // The line driver drops ready a cycle late, so ready is ignored here.
                state_d = StFetch;
                if (!rd_last_point) begin
                    rptr_d = rptr_q + ADDR_W'(1);
                end else begin
                    rptr_d  = '0;
                    do_swap = swap_pending_q;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (do_swap) begin
            front_bank_d   = ~front_bank_q;
            front_len_d    = back_len_q;
            rptr_d         = '0;
            frame_active_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            front_bank_q   <= 1'b0;
            front_len_q    <= '0;
            rptr_q         <= '0;
            x_q            <= '0;
            y_q            <= '0;
            frame_active_q <= 1'b0;
        end else begin
            front_bank_q   <= front_bank_d;
            front_len_q    <= front_len_d;
            rptr_q         <= rptr_d;
            x_q            <= x_d;
            y_q            <= y_d;
            frame_active_q <= frame_active_d;
        end
    end

    always_comb begin
        rd_en = 1'b0;
        draw  = 1'b0;
        jump  = 1'b0;
        unique case (state_q)
            StFetch: begin
                rd_en = 1'b1;
            end
            StIssue: begin
                draw = pt_beam(rd_word);
                jump = ~pt_beam(rd_word);
            end
            default: begin
            end
        endcase
    end

    assign x            = x_q;
    assign y            = y_q;
    assign frame_active = frame_active_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler: expected commands are queued as frames are written
// and popped as draw/jump pulses appear.
module tb_frame_scheduler;
    import vector_pkg::*;

    localparam int unsigned ADDR_W = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic [31:0] wr_point;
    logic        wr_last;
    logic        wr_ready;
    logic        ready;
    logic [11:0] x;
    logic [11:0] y;
    logic        draw;
    logic        jump;
    logic        frame_active;
    logic        overflow;

    int          checks   = 0;
    int          failures = 0;
    logic [25:0] sb_q[$];

    logic [31:0] fa[3];
    logic [31:0] pa[2];
    logic [31:0] pb[4];
    logic [31:0] pc[2];
    logic [31:0] pp[9];

    always #5 clk = ~clk;

    frame_scheduler #(
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_point     (wr_point),
        .wr_last      (wr_last),
        .wr_ready     (wr_ready),
        .ready        (ready),
        .x            (x),
        .y            (y),
        .draw         (draw),
        .jump         (jump),
        .frame_active (frame_active),
        .overflow     (overflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk_pt(input bit beam, input int xv, input int yv);
        logic [11:0] xc;
        logic [11:0] yc;
        xc = 12'(xv);
        yc = 12'(yv);
        return {7'd0, beam, xc, yc};
    endfunction

    // Expected command: {draw, jump, x, y}.
    function automatic logic [25:0] cmd_of(input logic [31:0] pt);
        return {pt[24], ~pt[24], pt[23:12], pt[11:0]};
    endfunction

    always @(negedge clk) begin
        if (draw || jump) begin
            if (draw && jump) begin
                check_eq("draw_jump_exclusive", 32'({draw, jump}), 32'b10);
            end
            if (sb_q.size() == 0) begin
                check_eq("pulse_unexpected", 32'({draw, jump, x, y}), 32'd0);
            end else begin
                check_eq("pulse_cmd", 32'({draw, jump, x, y}), 32'(sb_q.pop_front()));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the point is accepted.
    task automatic drive_point(input logic [31:0] pt, input logic last);
        int n;
        n = 0;
        while (!wr_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!wr_ready) begin
            check_eq("wr_ready_timeout", 32'(wr_ready), 32'd1);
        end
        wr_valid = 1'b1;
        wr_point = pt;
        wr_last  = last;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    // Returns at the negedge on which the n-th pulse is seen.
    task automatic wait_pulses(input int n);
        int got;
        int budget;
        got    = 0;
        budget = n * 12 + 30;
        while (got < n && budget > 0) begin
            @(negedge clk);
            if (draw || jump) begin
                got++;
            end
            budget--;
        end
        if (got != n) begin
            check_eq("pulse_timeout", 32'(got), 32'(n));
        end
    endtask

    task automatic run_pulses(input int n);
        ready = 1'b1;
        wait_pulses(n);
        ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        wr_point = '0;
        ready    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic count_stray(input int cycles, output int stray);
        stray = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (draw || jump) begin
                stray++;
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int stray;
        fa[0] = mk_pt(1'b0, 10, 20);
        fa[1] = mk_pt(1'b1, 100, 20);
        fa[2] = mk_pt(1'b1, 100, 200);
        pa[0] = mk_pt(1'b0, 1, 2);
        pa[1] = mk_pt(1'b1, 3, 4);
        pb[0] = mk_pt(1'b0, 50, 60);
        pb[1] = mk_pt(1'b1, 70, 60);
        pb[2] = mk_pt(1'b1, 70, 80);
        pb[3] = mk_pt(1'b1, 50, 80);
        pc[0] = mk_pt(1'b1, 200, 300);
        pc[1] = mk_pt(1'b0, 400, 500);
        for (int i = 0; i < 9; i++) begin
            pp[i] = mk_pt(i[0], 16 * i + 5, 300 - 7 * i);
        end

        // Reset state
        do_reset();
        @(negedge clk);
        check_eq("rst_draw", 32'(draw), 32'd0);
        check_eq("rst_jump", 32'(jump), 32'd0);
        check_eq("rst_x", 32'(x), 32'd0);
        check_eq("rst_y", 32'(y), 32'd0);
        check_eq("rst_frame_active", 32'(frame_active), 32'd0);
        check_eq("rst_overflow", 32'(overflow), 32'd0);
        check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic 3-point frame, replayed repeatedly
        for (int i = 0; i < 3; i++) begin
            drive_point(fa[i], i == 2);
        end
        check_eq("t1_wr_ready_pending", 32'(wr_ready), 32'd0);
        check_eq("t1_active_before_swap", 32'(frame_active), 32'd0);
        @(posedge clk);
        #1;
        check_eq("t1_active_after_swap", 32'(frame_active), 32'd1);
        check_eq("t1_wr_ready_after_swap", 32'(wr_ready), 32'd1);
        for (int i = 0; i < 7; i++) begin
            sb_q.push_back(cmd_of(fa[i % 3]));
        end
        run_pulses(7);
        check_eq("t1_frame_active", 32'(frame_active), 32'd1);

        // Stall mid-frame: nothing issued, x/y held, then exactly the next point
        count_stray(50, stray);
        check_eq("t2_no_pulse_stalled", 32'(stray), 32'd0);
        check_eq("t2_x_held", 32'(x), 32'd10);
        check_eq("t2_y_held", 32'(y), 32'd20);
        sb_q.push_back(cmd_of(fa[1]));
        @(posedge clk);
        #1;
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("t2_latency_draw", 32'(draw), 32'd1);
        check_eq("t2_latency_x", 32'(x), 32'd100);
        ready = 1'b0;
        sb_q.push_back(cmd_of(fa[2]));
        sb_q.push_back(cmd_of(fa[0]));
        run_pulses(2);
        check_eq("t2_sb_drained", 32'(sb_q.size()), 32'd0);

        // Frame B written during replay of A: A finishes its pass first
        do_reset();
        drive_point(pa[0], 1'b0);
        drive_point(pa[1], 1'b1);
        sb_q.push_back(cmd_of(pa[0]));
        run_pulses(1);
        for (int i = 0; i < 4; i++) begin
            drive_point(pb[i], i == 3);
        end
        check_eq("t3_wr_ready_after_last", 32'(wr_ready), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check_eq("t3_wr_ready_held", 32'(wr_ready), 32'd0);
        sb_q.push_back(cmd_of(pa[1]));
        run_pulses(1);
        check_eq("t3_wr_ready_gap", 32'(wr_ready), 32'd0);
        @(posedge clk);
        #1;
        check_eq("t3_wr_ready_swapped", 32'(wr_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back(cmd_of(pb[i % 4]));
        end
        run_pulses(5);

        // wr_last accepted on the frame-end GAP cycle: A replays once more
        do_reset();
        drive_point(pa[0], 1'b0);
        drive_point(pa[1], 1'b1);
        sb_q.push_back(cmd_of(pa[0]));
        run_pulses(1);
        drive_point(pc[0], 1'b0);
        sb_q.push_back(cmd_of(pa[1]));
        sb_q.push_back(cmd_of(pa[0]));
        sb_q.push_back(cmd_of(pa[1]));
        sb_q.push_back(cmd_of(pc[0]));
        sb_q.push_back(cmd_of(pc[1]));
        sb_q.push_back(cmd_of(pc[0]));
        ready = 1'b1;
        wait_pulses(1);
        @(posedge clk);
        #1;
        check_eq("t4_wr_ready_in_gap", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_point = pc[1];
        wr_last  = 1'b1;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        check_eq("t4_wr_ready_pending", 32'(wr_ready), 32'd0);
        wait_pulses(5);
        ready = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t4_sb_drained", 32'(sb_q.size()), 32'd0);

        // Overflow: 9 points without last into an 8-deep bank
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive_point(pp[i], 1'b0);
            if (i == 6) begin
                check_eq("t5_overflow_early", 32'(overflow), 32'd0);
            end
        end
        check_eq("t5_overflow_set", 32'(overflow), 32'd1);
        check_eq("t5_ninth_refused", 32'(wr_ready), 32'd0);
        drive_point(pp[8], 1'b0);
        for (int i = 0; i < 16; i++) begin
            sb_q.push_back(cmd_of(pp[i % 8]));
        end
        run_pulses(16);
        check_eq("t5_overflow_sticky", 32'(overflow), 32'd1);
        check_eq("t5_sb_drained", 32'(sb_q.size()), 32'd0);

        // Reset during ISSUE of point 2
        do_reset();
        check_eq("t6_overflow_cleared", 32'(overflow), 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive_point(fa[i], i == 2);
        end
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(cmd_of(fa[i]));
        end
        ready = 1'b1;
        wait_pulses(3);
        reset = 1'b1;
        @(negedge clk);
        check_eq("t6_draw", 32'(draw), 32'd0);
        check_eq("t6_jump", 32'(jump), 32'd0);
        check_eq("t6_x", 32'(x), 32'd0);
        check_eq("t6_y", 32'(y), 32'd0);
        check_eq("t6_frame_active", 32'(frame_active), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        count_stray(40, stray);
        check_eq("t6_no_pulse_after_reset", 32'(stray), 32'd0);
        check_eq("t6_still_inactive", 32'(frame_active), 32'd0);
        @(posedge clk);
        #1;
        // Minimum frame length: a single point
        drive_point(mk_pt(1'b1, 7, 9), 1'b1);
        sb_q.push_back(cmd_of(mk_pt(1'b1, 7, 9)));
        sb_q.push_back(cmd_of(mk_pt(1'b1, 7, 9)));
        wait_pulses(2);
        ready = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t6_active_new_frame", 32'(frame_active), 32'd1);
        check_eq("final_sb_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
